// File: rtl/riscv_slave_pkg.sv
// Shared types for the RISC-V slave request controller.
package riscv_slave_pkg;

    localparam int NPORTS = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RDW,
        WR,
        RESP
    } slave_ctrl_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves to the loser only on an accepted grant.
module rr_arbiter2
    import riscv_slave_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic [NPORTS-1:0] valid,
    input  logic              advance,
    output logic [NPORTS-1:0] grant,
    output logic              ptr
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~grant[1];
        end
    end

endmodule

// File: rtl/riscv_slave_ctrl.sv
// Two-port request controller for the slave register memory; partial-strobe
// writes are turned into a read-modify-write since the memory takes whole words only.
module riscv_slave_ctrl
    import riscv_slave_pkg::*;
#(
    parameter  int abits       = 4,
    parameter  int log2_dbytes = 3,
    localparam int dbytes      = 2 ** log2_dbytes,
    localparam int dbits       = 8 * dbytes
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [NPORTS-1:0]             i_req_valid,
    output logic [NPORTS-1:0]             o_req_ready,
    input  logic [NPORTS-1:0]             i_req_we,
    input  logic [NPORTS-1:0][abits-1:0]  i_req_addr,
    input  logic [NPORTS-1:0][dbytes-1:0] i_req_wstrb,
    input  logic [NPORTS-1:0][dbits-1:0]  i_req_wdata,
    output logic [NPORTS-1:0]             o_resp_valid,
    output logic [dbits-1:0]              o_resp_rdata,
    output logic [abits-1:0]              o_mem_addr,
    output logic                          o_mem_wena,
    output logic [dbits-1:0]              o_mem_wdata,
    input  logic [dbits-1:0]              i_mem_rdata
);

    slave_ctrl_state_t state;

    logic [NPORTS-1:0] grant;
    logic              arb_ptr;
    logic              accept;
    logic              gidx;
    logic              owner;
    logic              we;
    logic [dbytes-1:0] wstrb;
    logic [dbits-1:0]  wdata;
    logic [dbits-1:0]  merged;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .nrst    (nrst),
        .valid   (i_req_valid),
        .advance (accept),
        .grant   (grant),
        .ptr     (arb_ptr)
    );

    assign o_req_ready = (state == IDLE) ? grant : '0;
    assign accept      = |o_req_ready;
    assign gidx        = grant[1];

    for (genvar k = 0; k < dbytes; k++) begin : g_merge
        assign merged[8*k +: 8] = wstrb[k] ? wdata[8*k +: 8] : i_mem_rdata[8*k +: 8];
    end

    // Full-strobe and zero-strobe writes skip the read phase; zero strobe keeps wena low.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= IDLE;
            owner        <= 1'b0;
            we           <= 1'b0;
            wstrb        <= '0;
            wdata        <= '0;
            o_resp_valid <= '0;
            o_resp_rdata <= '0;
            o_mem_addr   <= '0;
            o_mem_wena   <= 1'b0;
            o_mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner      <= gidx;
                        we         <= i_req_we[gidx];
                        wstrb      <= i_req_wstrb[gidx];
                        wdata      <= i_req_wdata[gidx];
                        o_mem_addr <= i_req_addr[gidx];
                        if (i_req_we[gidx] && ((&i_req_wstrb[gidx]) || !(|i_req_wstrb[gidx]))) begin
                            o_mem_wdata <= i_req_wdata[gidx];
                            o_mem_wena  <= |i_req_wstrb[gidx];
                            state       <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    state <= RDW;
                end
                RDW: begin
                    if (we) begin
                        o_mem_wdata <= merged;
                        o_mem_wena  <= 1'b1;
                        state       <= WR;
                    end else begin
                        o_resp_rdata        <= i_mem_rdata;
                        o_resp_valid[owner] <= 1'b1;
                        state               <= RESP;
                    end
                end
                WR: begin
                    o_mem_wena          <= 1'b0;
                    o_resp_rdata        <= '0;
                    o_resp_valid[owner] <= 1'b1;
                    state               <= RESP;
                end
                RESP: begin
                    o_resp_valid <= '0;
                    o_resp_rdata <= '0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The arbiter pointer must always point away from the port just granted.
    ptr_follows_grant: assert property (
        @(posedge clk) disable iff (!nrst) accept |=> (arb_ptr == ~$past(gidx))
    );

endmodule
